// File: rtl/cov_pkg.sv
// rtl/cov_pkg.sv - shared types and triangle indexing for the covariance accumulator
package cov_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

  function automatic int np(input int ch);
    return ch * (ch + 1) / 2;
  endfunction

  // Row-major upper-triangle index of pair (i,j), i <= j.
  function automatic int pair_idx(input int ch, input int i, input int j);
    return i * ch - (i * (i - 1)) / 2 + (j - i);
  endfunction

endpackage

// File: rtl/cov_mac.sv
// rtl/cov_mac.sv - one channel-pair product/accumulate lane with shift and saturate
module cov_mac
  import cov_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int LOG2N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         acc_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         sat
);

  localparam int ACC_W = 2 * W + LOG2N;
  localparam int SH    = LOG2N + FRAC;

  logic signed [2*W-1:0]   a_x, b_x;
  logic signed [2*W-1:0]   prod_d, prod_q;
  logic                    vld_d, vld_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-W:0]        hi;

  always_comb begin
    a_x    = {{W{a[W-1]}}, a};
    b_x    = {{W{b[W-1]}}, b};
    prod_d = acc_in ? a_x * b_x : '0;
    vld_d  = acc_in;
    acc_d  = vld_q ? acc_q + {{LOG2N{prod_q[2*W-1]}}, prod_q} : acc_q;
    if (clr) begin
      prod_d = '0;
      vld_d  = 1'b0;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
      acc_q  <= acc_d;
    end
  end

  // Result fits when every bit above the W-bit field matches the sign.
  always_comb begin
    shifted = acc_q >>> SH;
    hi      = shifted[ACC_W-1:W-1];
    sat     = ~(&hi | ~|hi);
    if (sat) res = shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else     res = shifted[W-1:0];
  end

endmodule

// File: rtl/cov_accum.sv
// rtl/cov_accum.sv - frame-based streaming covariance estimator (top)
module cov_accum
  import cov_pkg::*;
#(
  parameter int CH        = 4,
  parameter int W         = 16,
  parameter int FRAC      = 12,
  parameter int N_SAMPLES = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      En,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH*W-1:0]           x_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [np(CH)*W-1:0]       cov_out,
  output logic                      sat_flag
);

  localparam int NP    = np(CH);
  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int CNT_W = LOG2N + 1;

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              drain_d, drain_q;
  logic [NP*W-1:0]   cov_d, cov_q;
  logic              sat_d, sat_q;
  logic [NP*W-1:0]   res_w;
  logic [NP-1:0]     sat_w;
  logic              accept;
  logic              clr;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign clr       = ~En | ((state_q == HOLD) & out_ready);
  assign cov_out   = cov_q;
  assign sat_flag  = sat_q;

  for (genvar i = 0; i < CH; i++) begin : g_row
    for (genvar j = i; j < CH; j++) begin : g_col
      localparam int K = pair_idx(CH, i, j);
      cov_mac #(.W(W), .FRAC(FRAC), .LOG2N(LOG2N)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .acc_in(accept),
        .a     (x_in[i*W +: W]),
        .b     (x_in[j*W +: W]),
        .res   (res_w[K*W +: W]),
        .sat   (sat_w[K])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    cov_d   = cov_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        drain_d = 1'b0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_SAMPLES - 1)) state_d = DRAIN;
        end
        drain_d = 1'b0;
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = HOLD;
          cov_d   = res_w;
          sat_d   = |sat_w;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything except the held result.
    if (!En) begin
      state_d = IDLE;
      cnt_d   = '0;
      drain_d = 1'b0;
      cov_d   = cov_q;
      sat_d   = sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      cov_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      cov_q   <= cov_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_cov_accum.sv
// tb/tb_cov_accum.sv - directed self-checking bench for cov_accum
module tb_cov_accum;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int NS = 128;
  localparam int NP = 10;

  logic            clk = 1'b0;
  logic            rst, en, in_valid, in_ready, out_valid, out_ready, sat_flag;
  logic [CH*W-1:0] x_in;
  logic [NP*W-1:0] cov_out;
  logic [15:0]     e [NP];
  logic [15:0]     v [CH];
  int              errors = 0;
  int              checks = 0;

  always #5 clk = ~clk;

  cov_accum #(.CH(CH), .W(W), .FRAC(12), .N_SAMPLES(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .En       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cov_out  (cov_out),
    .sat_flag (sat_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input int nsamp, input bit alt, input bit bubbles, input bit lat);
    int acc = 0;
    int guard = 0;
    logic [15:0] s;
    while (acc < nsamp && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < CH; c++) begin
        s = v[c];
        if (alt && c < 2 && acc[0]) s = -s;
        x_in[c*W +: W] = s;
      end
      if (in_valid && in_ready) acc++;
    end
    if (acc < nsamp) check("frame_timeout", 32'(acc), 32'(nsamp));
    if (lat) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("rdy_drop", 32'(in_ready), 32'd0);
      check("lat1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat2", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat3", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input logic exp_sat);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < NP; k++)
      check($sformatf("cov%0d", k), 32'(cov_out[k*W +: W]), 32'(e[k]));
    check("sat_flag", 32'(sat_flag), 32'(exp_sat));
  endtask

  task automatic consume(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = {CH{16'h7FFF}};
      check("hold_rdy", 32'(in_ready), 32'd0);
      check("hold_vld", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_vld", 32'(out_valid), 32'd0);
    check("hs_rdy", 32'(in_ready), 32'd1);
  endtask

  task automatic set_all(input logic [15:0] val);
    for (int k = 0; k < NP; k++) e[k] = val;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_cov", 32'(|cov_out), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // constant 1.0 on every channel
    v = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    set_all(16'h1000);
    run_frame(NS, 1'b0, 1'b0, 1'b1);
    expect_result(1'b0);
    consume(0);

    // mixed signs: x0=1, x1=-1, x2=0.5, x3=0
    v = '{16'h1000, 16'hF000, 16'h0800, 16'h0000};
    e = '{16'h1000, 16'hF000, 16'h0800, 16'h0000, 16'h1000,
          16'hF800, 16'h0000, 16'h0400, 16'h0000, 16'h0000};
    run_frame(NS, 1'b0, 1'b0, 1'b1);
    expect_result(1'b0);
    consume(0);

    // saturation
    v = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    set_all(16'h7FFF);
    run_frame(NS, 1'b0, 1'b0, 1'b1);
    expect_result(1'b1);
    consume(0);

    // bubbles, then 20 cycles of backpressure with samples offered in HOLD
    v = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    set_all(16'h1000);
    run_frame(NS, 1'b0, 1'b1, 1'b1);
    expect_result(1'b0);
    consume(20);
    check("hold_cov_kept", 32'(cov_out[15:0]), 32'h1000);

    // alternating sign on x0 and x1
    v = '{16'h1000, 16'h1000, 16'h0000, 16'h0000};
    e = '{16'h1000, 16'h1000, 16'h0000, 16'h0000, 16'h1000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_frame(NS, 1'b1, 1'b0, 1'b1);
    expect_result(1'b0);
    consume(0);

    // abort mid-frame with large samples, then a clean frame
    v = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_frame(50, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_rdy", 32'(in_ready), 32'd0);
    check("abort_vld", 32'(out_valid), 32'd0);
    check("abort_cov_kept", 32'(cov_out[31:16]), 32'h1000);
    en = 1'b1;
    v = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    set_all(16'h1000);
    run_frame(NS, 1'b0, 1'b0, 1'b1);
    expect_result(1'b0);

    // En falls together with out_ready: no new frame
    en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("abort_hs_rdy", 32'(in_ready), 32'd0);
    check("abort_hs_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("abort_hs_idle", 32'(in_ready), 32'd0);
    en = 1'b1;

    // reset mid-frame clears outputs
    run_frame(50, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_vld", 32'(out_valid), 32'd0);
    check("rst2_rdy", 32'(in_ready), 32'd0);
    check("rst2_cov", 32'(|cov_out), 32'd0);
    check("rst2_sat", 32'(sat_flag), 32'd0);
    @(negedge clk);
    check("rst2_restart", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
